// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI mode-0 responder.
package spi_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // SPI mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_sync_if.sv
// Pin-level SPI signals plus the local parallel word port of spi_slave_sync.
// SPI_SLAVE_OVERRUN_EN adds the rx_ack / rx_overrun receive handshake.
interface spi_slave_sync_if
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;
    logic                  load;
    logic [DATA_WIDTH-1:0] data_S;
    logic                  done_S;
    logic [DATA_WIDTH-1:0] rx_S;
    logic                  busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                  rx_ack;
    logic                  rx_overrun;
`endif

    modport slave (
`ifdef SPI_SLAVE_OVERRUN_EN
        input  rx_ack,
        output rx_overrun,
`endif
        input  SCLK, CS, MOSI, load, data_S,
        output MISO, done_S, rx_S, busy
    );

    modport master (
`ifdef SPI_SLAVE_OVERRUN_EN
        output rx_ack,
        input  rx_overrun,
`endif
        output SCLK, CS, MOSI, load, data_S,
        input  MISO, done_S, rx_S, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall detection
// on the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder clocked entirely by CLK_S; SCLK/CS/MOSI are oversampled.
// Define SPI_SLAVE_OVERRUN_EN to add the rx_ack / rx_overrun handshake.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input logic               CLK_S,
    input logic               reset_n,
    spi_slave_sync_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    spi_state_e            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_buf, w_tx_buf_nxt;
    logic                  r_pending, w_pending_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                  r_miso, w_miso_nxt;
    logic                  r_done, w_done_nxt;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic                  w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic                  w_cs_sync, w_cs_rise, w_cs_fall;
    logic                  w_mosi;
    logic                  w_sample_edge, w_shift_edge;
    logic [DATA_WIDTH-1:0] w_tx_src, w_tx_shifted, w_rx_shift_in;
    logic [CNT_W-1:0]      w_cnt_inc;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] word);
        return (MSB_FIRST != 0) ? word[DATA_WIDTH-1] : word[0];
    endfunction

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (SPI_CPOL)
    ) u_sclk_sync (
        .i_clk   (CLK_S),
        .i_rst_n (reset_n),
        .i_async (bus.SCLK),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // CS resets to its deasserted level so reset release never fakes a select.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .i_clk   (CLK_S),
        .i_rst_n (reset_n),
        .i_async (bus.CS),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    always_ff @(posedge CLK_S or negedge reset_n) begin
        if (!reset_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
        end
    end

    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample_edge = (SPI_CPOL == SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
    assign w_shift_edge  = (SPI_CPOL == SPI_CPHA) ? w_sclk_fall : w_sclk_rise;

    // A load in the same cycle as a reload supplies the reloaded word.
    assign w_tx_src      = bus.load ? bus.data_S : r_tx_buf;
    assign w_tx_shifted  = (MSB_FIRST != 0) ? {r_tx_shift[DATA_WIDTH-2:0], 1'b0}
                                            : {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
    assign w_rx_shift_in = (MSB_FIRST != 0) ? {r_rx_shift[DATA_WIDTH-2:0], w_mosi}
                                            : {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};
    assign w_cnt_inc     = r_cnt + 1'b1;

    // NOTE: every next-state value gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_buf_nxt   = w_tx_src;
        w_pending_nxt  = r_pending;
        w_cnt_nxt      = r_cnt;
        w_tx_shift_nxt = r_tx_shift;
        w_rx_shift_nxt = r_rx_shift;
        w_miso_nxt     = r_miso;
        w_done_nxt     = 1'b0;
        w_rx_nxt       = r_rx;

        case (r_state)
            ST_IDLE: begin
                w_miso_nxt = 1'b0;
                if (w_cs_fall) begin
                    w_state_nxt    = ST_ACTIVE;
                    w_tx_shift_nxt = w_tx_src;
                    w_pending_nxt  = 1'b0;
                    w_cnt_nxt      = '0;
                    w_miso_nxt     = first_bit(w_tx_src);
                end
            end

            ST_ACTIVE: begin
                if (bus.load) begin
                    w_pending_nxt = 1'b1;
                end
                // Deselect beats a coincident SCLK edge; mid-frame data is dropped.
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_miso_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_sample_edge) begin
                    w_rx_shift_nxt = w_rx_shift_in;
                    if (w_cnt_inc == CNT_W'(DATA_WIDTH)) begin
                        w_cnt_nxt      = '0;
                        w_rx_nxt       = w_rx_shift_in;
                        w_done_nxt     = 1'b1;
                        w_tx_shift_nxt = w_tx_src;
                        w_pending_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (w_shift_edge) begin
                    if (r_cnt != '0) begin
                        w_tx_shift_nxt = w_tx_shifted;
                        w_miso_nxt     = first_bit(w_tx_shifted);
                    end else begin
                        w_miso_nxt = first_bit(r_tx_shift);
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_S or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_tx_buf   <= '0;
            r_pending  <= 1'b0;
            r_cnt      <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_miso     <= 1'b0;
            r_done     <= 1'b0;
            r_rx       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tx_buf   <= w_tx_buf_nxt;
            r_pending  <= w_pending_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_miso     <= w_miso_nxt;
            r_done     <= w_done_nxt;
            r_rx       <= w_rx_nxt;
        end
    end

    assign bus.MISO   = r_miso;
    assign bus.done_S = r_done;
    assign bus.rx_S   = r_rx;
    assign bus.busy   = (r_state == ST_ACTIVE);

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_rx_valid;
    logic r_overrun;

    // Overrun is flagged on the same edge that raises done_S for the new word.
    always_ff @(posedge CLK_S or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_done_nxt) begin
            r_rx_valid <= 1'b1;
            r_overrun  <= r_rx_valid & ~bus.rx_ack;
        end else begin
            r_overrun <= 1'b0;
            if (bus.rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: an MSB-first and an LSB-first instance
// share the master pins; each frame is checked against hand-computed words.
module tb_spi_slave_sync;

    logic clk;
    logic reset_n;
    logic m_sclk;
    logic m_cs;
    logic m_mosi;

    int n_checks;
    int n_fail;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    int ovr_cnt;
    int ovr_coinc;

    spi_slave_sync_if #(.DATA_WIDTH(8)) if_m ();
    spi_slave_sync_if #(.DATA_WIDTH(8)) if_l ();

    assign if_m.SCLK = m_sclk;
    assign if_m.CS   = m_cs;
    assign if_m.MOSI = m_mosi;
    assign if_l.SCLK = m_sclk;
    assign if_l.CS   = m_cs;
    assign if_l.MOSI = m_mosi;

    spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(1)) u_dut_msb (
        .CLK_S   (clk),
        .reset_n (reset_n),
        .bus     (if_m)
    );

    spi_slave_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2), .MSB_FIRST(0)) u_dut_lsb (
        .CLK_S   (clk),
        .reset_n (reset_n),
        .bus     (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_m.done_S) q_m.push_back(if_m.rx_S);
        if (if_l.done_S) q_l.push_back(if_l.rx_S);
`ifdef SPI_SLAVE_OVERRUN_EN
        if (if_m.rx_overrun) ovr_cnt++;
        if (if_m.rx_overrun && if_m.done_S) ovr_coinc++;
`endif
    end

    typedef struct {
        logic [7:0] load_val;
        logic [7:0] mosi_val;
        logic [7:0] exp_rx;
        logic [7:0] exp_master;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_m(input logic [7:0] v);
        @(negedge clk);
        if_m.data_S = v;
        if_m.load   = 1'b1;
        @(negedge clk);
        if_m.load   = 1'b0;
    endtask

    task automatic load_l(input logic [7:0] v);
        @(negedge clk);
        if_l.data_S = v;
        if_l.load   = 1'b1;
        @(negedge clk);
        if_l.load   = 1'b0;
    endtask

    task automatic cs_low();
        m_cs = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #80;
        m_cs = 1'b1;
        #80;
    endtask

    // Mode-0 master: MOSI changes while SCLK is low, MISO sampled just before the rise.
    task automatic shift_bits(input logic [7:0] tx, input bit msb, input int n,
                              output logic [7:0] rx_m, output logic [7:0] rx_l);
        rx_m = '0;
        rx_l = '0;
        for (int i = 0; i < n; i++) begin
            int b;
            b = msb ? 7 - i : i;
            m_mosi = tx[b];
            #40;
            rx_m[b] = if_m.MISO;
            rx_l[b] = if_l.MISO;
            m_sclk  = 1'b1;
            #40;
            m_sclk  = 1'b0;
        end
    endtask

    vec_t       vecs[3];
    logic [7:0] rm, rl, rm1, rm2;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ovr_cnt  = 0;
        ovr_coinc = 0;
        reset_n  = 1'b0;
        m_sclk   = 1'b0;
        m_cs     = 1'b1;
        m_mosi   = 1'b0;
        if_m.load = 1'b0; if_m.data_S = '0;
        if_l.load = 1'b0; if_l.data_S = '0;
`ifdef SPI_SLAVE_OVERRUN_EN
        if_m.rx_ack = 1'b0;
        if_l.rx_ack = 1'b0;
`endif

        vecs[0] = '{load_val: 8'h3C, mosi_val: 8'h96, exp_rx: 8'h96, exp_master: 8'h3C};
        vecs[1] = '{load_val: 8'hFF, mosi_val: 8'h00, exp_rx: 8'h00, exp_master: 8'hFF};
        vecs[2] = '{load_val: 8'hCA, mosi_val: 8'hB3, exp_rx: 8'hB3, exp_master: 8'hCA};

        repeat (3) @(negedge clk);
        check("reset MISO",   {31'd0, if_m.MISO},   32'd0);
        check("reset done_S", {31'd0, if_m.done_S}, 32'd0);
        check("reset rx_S",   {24'd0, if_m.rx_S},   32'd0);
        check("reset busy",   {31'd0, if_m.busy},   32'd0);
        check("reset lsb busy", {31'd0, if_l.busy}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single framed exchanges; the last row is the basic 0xCA / 0xB3 case.
        for (int v = 0; v < 3; v++) begin
            q_m.delete();
            load_m(vecs[v].load_val);
            cs_low();
            shift_bits(vecs[v].mosi_val, 1'b1, 8, rm, rl);
            cs_high();
            check($sformatf("vec%0d done count", v), q_m.size(), 32'd1);
            check($sformatf("vec%0d done word", v), {24'd0, q_m[0]}, {24'd0, vecs[v].exp_rx});
            check($sformatf("vec%0d rx_S", v), {24'd0, if_m.rx_S}, {24'd0, vecs[v].exp_rx});
            check($sformatf("vec%0d master rx", v), {24'd0, rm}, {24'd0, vecs[v].exp_master});
            check($sformatf("vec%0d busy idle", v), {31'd0, if_m.busy}, 32'd0);
            check($sformatf("vec%0d MISO idle", v), {31'd0, if_m.MISO}, 32'd0);
        end

        // CS abort after five bits.
        q_m.delete();
        cs_low();
        shift_bits(8'hFF, 1'b1, 5, rm, rl);
        check("abort busy mid", {31'd0, if_m.busy}, 32'd1);
        cs_high();
        check("abort no done", q_m.size(), 32'd0);
        check("abort rx_S kept", {24'd0, if_m.rx_S}, 32'hB3);
        check("abort busy", {31'd0, if_m.busy}, 32'd0);
        check("abort MISO", {31'd0, if_m.MISO}, 32'd0);

        // Reset mid-frame after the fourth rise.
        load_m(8'h81);
        cs_low();
        shift_bits(8'hC3, 1'b1, 4, rm, rl);
        #20;
        reset_n = 1'b0;
        #1;
        check("midrst MISO", {31'd0, if_m.MISO}, 32'd0);
        check("midrst done_S", {31'd0, if_m.done_S}, 32'd0);
        check("midrst rx_S", {24'd0, if_m.rx_S}, 32'd0);
        check("midrst busy", {31'd0, if_m.busy}, 32'd0);
        m_cs   = 1'b1;
        m_sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        q_m.delete();
        load_m(8'h3F);
        cs_low();
        shift_bits(8'h5A, 1'b1, 8, rm, rl);
        cs_high();
        check("postrst done count", q_m.size(), 32'd1);
        check("postrst rx_S", {24'd0, if_m.rx_S}, 32'h5A);
        check("postrst master rx", {24'd0, rm}, 32'h3F);

        // Back-to-back frames with CS held low; new tx word loaded during frame 1.
        load_m(8'h77);
        q_m.delete();
        cs_low();
        fork
            begin
                shift_bits(8'h12, 1'b1, 8, rm1, rl);
                shift_bits(8'h34, 1'b1, 8, rm2, rl);
            end
            begin
                #200;
                load_m(8'hA5);
            end
        join
        cs_high();
        check("b2b done count", q_m.size(), 32'd2);
        check("b2b word1", {24'd0, q_m[0]}, 32'h12);
        check("b2b word2", {24'd0, q_m[1]}, 32'h34);
        check("b2b master1", {24'd0, rm1}, 32'h77);
        check("b2b master2", {24'd0, rm2}, 32'hA5);
        check("b2b rx_S", {24'd0, if_m.rx_S}, 32'h34);

        // LSB-first instance.
        load_l(8'h80);
        q_l.delete();
        cs_low();
        shift_bits(8'h01, 1'b0, 8, rm, rl);
        cs_high();
        check("lsb done count", q_l.size(), 32'd1);
        check("lsb rx_S", {24'd0, if_l.rx_S}, 32'h01);
        check("lsb master rx", {24'd0, rl}, 32'h80);

`ifdef SPI_SLAVE_OVERRUN_EN
        @(negedge clk);
        if_m.rx_ack = 1'b1;
        @(negedge clk);
        if_m.rx_ack = 1'b0;
        ovr_cnt   = 0;
        ovr_coinc = 0;
        for (int f = 0; f < 2; f++) begin
            cs_low();
            shift_bits(8'h3C + 8'(f), 1'b1, 8, rm, rl);
            cs_high();
        end
        check("overrun pulses", ovr_cnt, 32'd1);
        check("overrun with done", ovr_coinc, 32'd1);
        check("overrun rx_S", {24'd0, if_m.rx_S}, 32'h3D);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
